div_seq_32bits: RTL and testbench

//  Multi-cycle signed/unsigned integer divider: the inverse of the combinational mul_*_32bits ops.

---
 rtl/div_seq_32bits_pkg.sv | 15 +
 rtl/div_seq_32bits_if.sv | 25 ++
 rtl/div_seq_32bits_negate.sv | 9 +
 rtl/div_seq_32bits.sv | 134 +++++++++++++
 tb/tb_div_seq_32bits.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_32bits_pkg.sv
// Shared constants for the sequential divider: state encodings, default width, signed minimum.
package div_seq_32bits_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_CALC = 2'd1;
  localparam div_state_t DIV_FIX  = 2'd2;
  localparam div_state_t DIV_DONE = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_seq_32bits_if.sv
// Operand/result handshake bundle between the issue logic (master) and the divider (slave).
interface div_seq_32bits_if #(
  parameter int DATA_WIDTH = div_seq_32bits_pkg::DATA_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_signed;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] r;
  logic                  overflow;

  modport master (
    output in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, s, r, overflow
  );

  modport slave (
    input  in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, s, r, overflow
  );
endinterface

// File: rtl/div_seq_32bits_negate.sv
// Two's-complement negation, used for operand magnitudes and the sign fixup of the results.
module twos_negate_32bits #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] s
);
  assign s = ~a + DATA_WIDTH'(1);
endmodule

// File: rtl/div_seq_32bits.sv
// Restoring radix-2 signed/unsigned divider, one quotient bit per clock.
// Optional macro DIV_FAST_ZERO_EN: finish in one cycle when |a| < |b|.
module div_seq_32bits
  import div_seq_32bits_pkg::*;
#(
  parameter int DATA_WIDTH = div_seq_32bits_pkg::DATA_WIDTH
) (
  input logic clk,
  input logic rst,
  div_seq_32bits_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  div_state_t state, state_nx;
  logic [CW-1:0] count;
  logic [W-1:0] rem, quo, bmag;
  logic sign_a, sign_q;

  logic [W-1:0] s_q, r_q, s_d, r_d;
  logic ovf_q, ovf_d;
  logic in_ready_q, out_valid_q, in_ready_d, out_valid_d;

  logic [W-1:0] a_neg, b_neg, q_neg, r_neg, a_mag, b_mag;
  logic accept, b_zero, min_ovf, fast_zero, fast;
  logic [W:0] rem_sh;
  logic ge;
  logic [W-1:0] rem_nx, quo_nx;

  twos_negate_32bits #(.DATA_WIDTH(W)) u_neg_a (.a(bus.a), .s(a_neg));
  twos_negate_32bits #(.DATA_WIDTH(W)) u_neg_b (.a(bus.b), .s(b_neg));
  twos_negate_32bits #(.DATA_WIDTH(W)) u_neg_q (.a(quo),   .s(q_neg));
  twos_negate_32bits #(.DATA_WIDTH(W)) u_neg_r (.a(rem),   .s(r_neg));

  assign a_mag   = (bus.is_signed && bus.a[W-1]) ? a_neg : bus.a;
  assign b_mag   = (bus.is_signed && bus.b[W-1]) ? b_neg : bus.b;
  assign accept  = bus.in_valid && in_ready_q;
  assign b_zero  = (bus.b == '0);
  assign min_ovf = bus.is_signed && (bus.a == MIN_W) && (bus.b == '1);

`ifdef DIV_FAST_ZERO_EN
  assign fast_zero = !b_zero && (a_mag < b_mag);
`else
  assign fast_zero = 1'b0;
`endif

  assign fast = b_zero || min_ovf || fast_zero;

  // Shifted remainder is kept W+1 bits wide: divisors above 2^(W-1) push it past W bits.
  assign rem_sh = {rem, quo[W-1]};
  assign ge     = (rem_sh >= {1'b0, bmag});
  assign rem_nx = ge ? (rem_sh[W-1:0] - bmag) : rem_sh[W-1:0];
  assign quo_nx = {quo[W-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE: if (accept) state_nx = fast ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (count == CW'(1)) state_nx = DIV_FIX;
      DIV_FIX:  state_nx = DIV_DONE;
      DIV_DONE: if (bus.out_ready) state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  // Handshake flags and results are computed from the next state and then registered.
  always_comb begin
    in_ready_d  = (state_nx == DIV_IDLE);
    out_valid_d = (state_nx == DIV_DONE);
    s_d   = s_q;
    r_d   = r_q;
    ovf_d = ovf_q;
    if (state == DIV_IDLE && accept && fast) begin
      if (b_zero) begin
        s_d = '1;    r_d = bus.a; ovf_d = 1'b1;
      end else if (min_ovf) begin
        s_d = MIN_W; r_d = '0;    ovf_d = 1'b1;
      end else begin
        s_d = '0;    r_d = bus.a; ovf_d = 1'b0;
      end
    end else if (state == DIV_FIX) begin
      s_d   = sign_q ? q_neg : quo;
      r_d   = sign_a ? r_neg : rem;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      bmag        <= '0;
      sign_a      <= 1'b0;
      sign_q      <= 1'b0;
      count       <= '0;
    end else begin
      s_q         <= s_d;
      r_q         <= r_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (state == DIV_IDLE && accept) begin
        rem    <= '0;
        quo    <= a_mag;
        bmag   <= b_mag;
        sign_a <= bus.is_signed && bus.a[W-1];
        sign_q <= bus.is_signed && (bus.a[W-1] ^ bus.b[W-1]);
        count  <= CW'(W);
      end else if (state == DIV_CALC) begin
        rem   <= rem_nx;
        quo   <= quo_nx;
        count <= count - CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_div_seq_32bits.sv
// Self-checking bench for div_seq_32bits: vector table, corner sequences, random ops vs a reference model.
module tb_div_seq_32bits;
  import div_seq_32bits_pkg::*;

  localparam int W        = DATA_WIDTH;
  localparam int LAT_FULL = W + 2;

  typedef struct {
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  div_seq_32bits_if #(.DATA_WIDTH(W)) bus ();
  div_seq_32bits #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.lat = LAT_FULL;
    e.ovf = 1'b0;
    if (b == '0) begin
      e.s = '1; e.r = a; e.ovf = 1'b1; e.lat = 1;
    end else if (sg && a == MIN && b == '1) begin
      e.s = MIN; e.r = '0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      if (sg) begin
        e.s = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.s = a / b;
        e.r = a % b;
      end
`ifdef DIV_FAST_ZERO_EN
      begin
        logic [W-1:0] am, bm;
        am = (sg && a[W-1]) ? -a : a;
        bm = (sg && b[W-1]) ? -b : b;
        if (am < bm) e.lat = 1;
      end
`endif
    end
    return e;
  endfunction

  // Issue one op, measure latency from the accept edge, optionally stall the result, then retire it.
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    exp_t e;
    int edges;
    int waits;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk1({tag, ".in_ready_pre"}, bus.in_ready, 1'b1);
    sb.push_back(model(sg, a, b));
    bus.in_valid  = 1'b1;
    bus.is_signed = sg;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    edges = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    while (!bus.out_valid && edges < LAT_FULL + 10) begin
      @(posedge clk);
      edges++;
      #1;
    end
    e = sb.pop_front();
    chki({tag, ".latency"}, edges, e.lat);
    chk ({tag, ".s"}, bus.s, e.s);
    chk ({tag, ".r"}, bus.r, e.r);
    chk1({tag, ".ovf"}, bus.overflow, e.ovf);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk ({tag, ".hold_s"}, bus.s, e.s);
      chk ({tag, ".hold_r"}, bus.r, e.r);
      chk1({tag, ".hold_ovf"}, bus.overflow, e.ovf);
      chk1({tag, ".hold_out_valid"}, bus.out_valid, 1'b1);
      chk1({tag, ".hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk1({tag, ".post_out_valid"}, bus.out_valid, 1'b0);
    chk1({tag, ".post_in_ready"}, bus.in_ready, 1'b1);
    chk ({tag, ".post_s_kept"}, bus.s, e.s);
  endtask

  initial begin
    vec_t tbl[12];
    int waits;

    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1};
    tbl[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};
    tbl[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    tbl[11] = '{1'b0, 32'd3,          32'h7FFF_FFFD,  32'd0,          32'd3,          1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk1("reset.in_ready", bus.in_ready, 1'b1);
    chk1("reset.out_valid", bus.out_valid, 1'b0);
    chk ("reset.s", bus.s, '0);
    chk ("reset.r", bus.r, '0);
    chk1("reset.ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table entries double as a sanity check on the reference model.
    foreach (tbl[i]) begin
      exp_t m;
      m = model(tbl[i].sg, tbl[i].a, tbl[i].b);
      chk ($sformatf("tbl%0d.model_s", i), m.s, tbl[i].s);
      chk ($sformatf("tbl%0d.model_r", i), m.r, tbl[i].r);
      run_op(tbl[i].sg, tbl[i].a, tbl[i].b, 0, $sformatf("tbl%0d", i));
    end

    run_op(1'b0, 32'd1000, 32'd10, 5, "bp_full");
    run_op(1'b0, 32'd9, 32'd0, 5, "bp_fast");

    // Reset on the 10th CALC cycle discards the op.
    @(negedge clk);
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    bus.in_valid  = 1'b1;
    bus.is_signed = 1'b0;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk1("midrst.busy_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("midrst.out_valid", bus.out_valid, 1'b0);
    chk1("midrst.in_ready", bus.in_ready, 1'b1);
    chk ("midrst.s", bus.s, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk1("midrst.no_stale_valid", bus.out_valid, 1'b0);
    run_op(1'b0, 32'd3, 32'h7FFF_FFFD, 0, "fastzero");

    for (int k = 0; k < 12; k++) begin
      logic         sg;
      logic [W-1:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = (k % 3 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
      if (k % 4 == 1) a = W'($urandom_range(0, 1000));
      run_op(sg, a, b, k % 2, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
